led_scan_pwm: RTL and testbench
===============================

// Module: led_scan_pwm
// PURPOSE
//  Consumer side of the painter interface: scans a 64x64 HUB75 panel (1/32 scan). It issues
//  (frame, subframe, x, y) requests to a painter, takes back rgb24 one cycle later, applies
//  gamma, and compares against subframe for PWM. It shifts column data and drives address,
//  latch and OE. The top level packs its outputs onto LED_PANEL[15:0].
// PARAMETERS
//  FRAME_BITS  6  width of the frame counter sent to the painter
//  DELAY       1  extra display-hold cycles per row (0 = none)
// PORTS
//  clk       in   1   system clock, single domain
//  resetn    in   1   asynchronous, active-low reset
//  frame     out  FRAME_BITS  frame number to painter
//  subframe  out  8   PWM subframe 0..254 to painter
//  x         out  6   requested column
//  y         out  6   requested row
//  rgb24     in   24  {b,g,r} from painter, valid exactly 1 clk after x/y
//  rgb0/rgb1 out  3+3 {b,g,r} bits for upper (rows 0-31) / lower (rows 32-63) half
//  addr      out  5   row address
//  sclk      out  1   panel shift clock, data sampled on rising edge
//  latch     out  1   panel latch strobe
//  oe_n      out  1   panel output enable (1 = dark)
// BEHAVIOUR
//  - Reset (async assert, sync release): oe_n=1; all other outputs 0; FSM=SHIFT; all counters 0.
//  - FSM: SHIFT(128) -> DRAIN(2) -> BLANK(1) -> LATCH(1) -> UNBLANK(1) -> HOLD(DELAY) -> SHIFT.
//    DELAY=0 skips HOLD.
//  - SHIFT, request index k=0..127: x=k[6:1], y={k[0],row}. Even k requests the upper
//    pixel, odd k the lower pixel.
//  - Response for k is sampled at cycle k+1. Upper bits are held in a register.
//  - On the lower response: rgb0/rgb1 update and sclk<=0. On the next cycle sclk<=1.
//    The panel therefore sees exactly 64 rising edges per row.
//  - DRAIN: waits for the last response and the final sclk rise. sclk returns to 0.
//  - Per channel c (8b): g=(c*c+255)>>8 (16b product). Bit is on iff g>subframe.
//    c=0 is never on; c=255 is on in all 255 subframes.
//  - While the next row shifts, the previous row stays displayed (oe_n=0).
//    The first row after reset is displayed dark.
//  - BLANK: oe_n<=1, addr<=row. LATCH: latch=1 for exactly 1 clk. UNBLANK: latch=0, oe_n<=0.
//  - addr changes only while oe_n=1.
//  - After UNBLANK: row increments, wrapping 31->0.
//  - On row wrap: subframe increments, wrapping 254->0.
//  - On subframe wrap: frame increments, wrapping naturally at 2^FRAME_BITS.
//  - frame and subframe are constant across all 128 requests of a row.
//    x and y are held at 0 outside SHIFT.
//  - Row period = 133+DELAY clk. Frame = 32*255 rows.
//  - rgb24 is ignored outside the response cycles. No backpressure: the painter must
//    meet the 1-cycle latency.
//  - Reset mid-row: immediate oe_n=1, sclk=0, latch=0. Scan restarts at row 0,
//    subframe 0, frame 0.
// TESTING
//  1 Reset release -> oe_n=1, sclk=0, x=y=0. First 128 cycles: x=0,0,1,1..63,63;
//    y alternates 0/32.
//  2 Painter constant 0xFFFFFF -> rgb0=rgb1=3'b111 on all 64 sclk rises of every
//    subframe; oe_n low 130+DELAY of every 133+DELAY clk.
//  3 Painter r=16, g=b=0 -> g=1: red on only in subframe 0; off in subframes 1..254.
//  4 Painter returns y as colour -> upper/lower data never swapped; addr 0..31 in order;
//    latch 1-clk pulse only with oe_n=1.
//  5 Run a full frame with FRAME_BITS=2 -> subframe 254->0 bumps frame; frame 3->0 wraps;
//    row period = 133+DELAY for DELAY=0 and 3.
//  6 Assert resetn at request k=70 -> outputs reset asynchronously; scan resumes at
//    x=0, y=0, subframe 0.

Source files
------------

// File: rtl/led_scan_pwm.sv
// HUB75 64x64 (1/32 scan) consumer: requests pixels from a painter, applies gamma and
// PWM against the subframe, and drives column data, row address, latch and output enable.
module led_scan_pwm #(
  parameter int FRAME_BITS = 6,
  parameter int DELAY      = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic [FRAME_BITS-1:0] frame,
  output logic [7:0]            subframe,
  output logic [5:0]            x,
  output logic [5:0]            y,
  input  logic [23:0]           rgb24,
  output logic [2:0]            rgb0,
  output logic [2:0]            rgb1,
  output logic [4:0]            addr,
  output logic                  sclk,
  output logic                  latch,
  output logic                  oe_n
);

  // state   | meaning
  // SHIFT   | 128 pixel requests, column data shifted out behind them
  // DRAIN   | 2 clk: last response and final sclk rise
  // BLANK   | panel dark, row address updated
  // LATCH   | 1 clk latch strobe
  // UNBLANK | re-enable display, advance row/subframe/frame
  // HOLD    | DELAY extra display cycles
  typedef enum logic [2:0] {S_SHIFT, S_DRAIN, S_BLANK, S_LATCH, S_UNBLANK, S_HOLD} state_t;

  localparam int TW = (DELAY > 2) ? $clog2(DELAY) : 1;

  state_t                state_q, state_d;
  logic [6:0]            k_q, k_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [4:0]            row_q, row_d;
  logic [7:0]            sub_q, sub_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;

  logic       rsp_vld_q, rsp_low_q;
  logic [2:0] upper_q, rgb0_q, rgb1_q;
  logic       sclk_pend_q, sclk_q, latch_q, oe_n_q;
  logic [4:0] addr_q;
  logic [2:0] pwm_bits;

  function automatic logic pwm_on(input logic [7:0] c, input logic [7:0] s);
    logic [15:0] c16;
    logic [15:0] g;
    c16 = {8'd0, c};
    g   = c16 * c16 + 16'd255;
    return g[15:8] > s;
  endfunction

  assign pwm_bits = {pwm_on(rgb24[23:16], sub_q), pwm_on(rgb24[15:8], sub_q),
                     pwm_on(rgb24[7:0], sub_q)};

  always_comb begin
    state_d = state_q;
    k_d     = '0;
    tmr_d   = tmr_q;
    row_d   = row_q;
    sub_d   = sub_q;
    frame_d = frame_q;
    case (state_q)
      S_SHIFT: begin
        k_d = k_q + 7'd1;
        if (k_q == 7'd127) begin
          state_d = S_DRAIN;
          tmr_d   = TW'(1);
        end
      end
      S_DRAIN: begin
        if (tmr_q == '0) state_d = S_BLANK;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: state_d = S_UNBLANK;
      S_UNBLANK: begin
        row_d = row_q + 5'd1;
        if (row_q == 5'd31) begin
          if (sub_q == 8'd254) begin
            sub_d   = '0;
            frame_d = frame_q + FRAME_BITS'(1);
          end else begin
            sub_d = sub_q + 8'd1;
          end
        end
        if (DELAY == 0) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_HOLD;
          tmr_d   = TW'((DELAY > 0) ? DELAY - 1 : 0);
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) state_d = S_SHIFT;
        else             tmr_d   = tmr_q - TW'(1);
      end
      default: state_d = S_SHIFT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_SHIFT;
      k_q     <= '0;
      tmr_q   <= '0;
      row_q   <= '0;
      sub_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tmr_q   <= tmr_d;
      row_q   <= row_d;
      sub_q   <= sub_d;
      frame_q <= frame_d;
    end
  end

  // Responses arrive one clk after the request; the upper pixel waits for its lower partner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_vld_q   <= 1'b0;
      rsp_low_q   <= 1'b0;
      upper_q     <= '0;
      rgb0_q      <= '0;
      rgb1_q      <= '0;
      sclk_pend_q <= 1'b0;
      sclk_q      <= 1'b0;
      latch_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      addr_q      <= '0;
    end else begin
      rsp_vld_q   <= (state_q == S_SHIFT);
      rsp_low_q   <= k_q[0];
      sclk_pend_q <= 1'b0;
      sclk_q      <= sclk_pend_q;
      if (rsp_vld_q) begin
        if (!rsp_low_q) begin
          upper_q <= pwm_bits;
        end else begin
          rgb0_q      <= upper_q;
          rgb1_q      <= pwm_bits;
          sclk_pend_q <= 1'b1;
        end
      end
      latch_q <= (state_q == S_BLANK);
      if (state_q == S_BLANK) addr_q <= row_q;
      if (state_q == S_DRAIN && state_d == S_BLANK) oe_n_q <= 1'b1;
      else if (state_q == S_UNBLANK)                oe_n_q <= 1'b0;
    end
  end

  assign x        = (state_q == S_SHIFT) ? k_q[6:1] : 6'd0;
  assign y        = (state_q == S_SHIFT) ? {k_q[0], row_q} : 6'd0;
  assign frame    = frame_q;
  assign subframe = sub_q;
  assign rgb0     = rgb0_q;
  assign rgb1     = rgb1_q;
  assign addr     = addr_q;
  assign sclk     = sclk_q;
  assign latch    = latch_q;
  assign oe_n     = oe_n_q;

endmodule

// File: tb/tb_led_scan_pwm.sv
// Bench for led_scan_pwm: cycle-timed reference model of the scan, constant-colour
// vector table, mid-row reset sequence and row-period checks for DELAY=0 and DELAY=3.
module tb_led_scan_pwm;

  localparam int D  = 1;
  localparam int P  = 133 + D;
  localparam int FB = 2;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic [FB-1:0] frame;
  logic [7:0]    subframe;
  logic [5:0]    x, y;
  logic [23:0]   rgb24 = '0;
  logic [2:0]    rgb0, rgb1;
  logic [4:0]    addr;
  logic          sclk, latch, oe_n;

  logic [5:0]  frame_a, frame_b;
  logic [7:0]  subframe_a, subframe_b;
  logic [5:0]  x_a, y_a, x_b, y_b;
  logic [23:0] rgb24_a = '0, rgb24_b = '0;
  logic [2:0]  rgb0_a, rgb1_a, rgb0_b, rgb1_b;
  logic [4:0]  addr_a, addr_b;
  logic        sclk_a, latch_a, oe_n_a, sclk_b, latch_b, oe_n_b;

  led_scan_pwm #(.FRAME_BITS(FB), .DELAY(D)) u_dut (
    .clk(clk), .resetn(resetn), .frame(frame), .subframe(subframe), .x(x), .y(y),
    .rgb24(rgb24), .rgb0(rgb0), .rgb1(rgb1), .addr(addr), .sclk(sclk), .latch(latch),
    .oe_n(oe_n));

  led_scan_pwm #(.FRAME_BITS(6), .DELAY(0)) u_d0 (
    .clk(clk), .resetn(resetn), .frame(frame_a), .subframe(subframe_a), .x(x_a), .y(y_a),
    .rgb24(rgb24_a), .rgb0(rgb0_a), .rgb1(rgb1_a), .addr(addr_a), .sclk(sclk_a),
    .latch(latch_a), .oe_n(oe_n_a));

  led_scan_pwm #(.FRAME_BITS(6), .DELAY(3)) u_d3 (
    .clk(clk), .resetn(resetn), .frame(frame_b), .subframe(subframe_b), .x(x_b), .y(y_b),
    .rgb24(rgb24_b), .rgb0(rgb0_b), .rgb1(rgb1_b), .addr(addr_b), .sclk(sclk_b),
    .latch(latch_b), .oe_n(oe_n_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bits lit for colour c in subframe s: channel on when round-up(c^2/256) exceeds s.
  function automatic int exp_bits(input logic [23:0] c, input int s);
    int r, v;
    r = 0;
    for (int ch = 0; ch < 3; ch++) begin
      v = int'(c[ch*8 +: 8]);
      if ((v * v + 255) / 256 > s) r += (1 << ch);
    end
    return r;
  endfunction

  // Painter: picture table, answers one clk after the request.
  logic [23:0] pix [64][64];
  logic [23:0] pend;
  always @(negedge clk) pend = pix[y][x];
  always @(posedge clk) rgb24 <= pend;

  task automatic fill(input int mode, input logic [23:0] col);
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 64; xx++)
        case (mode)
          0:       pix[yy][xx] = col;
          1:       pix[yy][xx] = 24'($urandom);
          default: pix[yy][xx] = {3{8'(yy * 4)}};
        endcase
  endtask

  int cyc;
  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  // Reference model: every output is a function of cycles since reset release.
  int m_t, m_n, m_ne, m_l, m_j, m_s;
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_oe_n", int'(oe_n), 1);
      chk("rst_sclk", int'(sclk), 0);
      chk("rst_latch", int'(latch), 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_addr", int'(addr), 0);
      chk("rst_rgb", int'({rgb0, rgb1}), 0);
      chk("rst_sub", int'(subframe), 0);
      chk("rst_frame", int'(frame), 0);
    end else begin
      m_t  = cyc % P;
      m_n  = cyc / P;
      m_ne = (cyc + D) / P;
      m_l  = (cyc >= 131) ? (cyc - 131) / P + 1 : 0;
      chk("x", int'(x), (m_t < 128) ? m_t / 2 : 0);
      chk("y", int'(y), (m_t < 128) ? (m_t % 2) * 32 + m_n % 32 : 0);
      chk("sclk", int'(sclk), (m_t >= 4 && m_t <= 130 && m_t % 2 == 0) ? 1 : 0);
      chk("latch", int'(latch), (m_t == 131) ? 1 : 0);
      chk("oe_n", int'(oe_n), (cyc < 133 || (m_t >= 130 && m_t <= 132)) ? 1 : 0);
      chk("addr", int'(addr), (m_l == 0) ? 0 : (m_l - 1) % 32);
      chk("subframe", int'(subframe), (m_ne / 32) % 255);
      chk("frame", int'(frame), (m_ne / (32 * 255)) % 4);
      if (m_t >= 4 && m_t <= 130 && m_t % 2 == 0) begin
        m_j = (m_t - 4) / 2;
        m_s = (m_n / 32) % 255;
        chk("rgb0", int'(rgb0), exp_bits(pix[m_n % 32][m_j], m_s));
        chk("rgb1", int'(rgb1), exp_bits(pix[m_n % 32 + 32][m_j], m_s));
      end
    end
  end

  // Row period and dark time for the DELAY=0 and DELAY=3 instances, latch to latch.
  int  a_cnt, a_low, b_cnt, b_low;
  bit  a_seen, b_seen;
  always @(negedge clk) begin
    if (!resetn) begin
      a_seen = 1'b0; a_cnt = 0; a_low = 0;
      b_seen = 1'b0; b_cnt = 0; b_low = 0;
    end else begin
      a_cnt++; b_cnt++;
      if (!oe_n_a) a_low++;
      if (!oe_n_b) b_low++;
      if (latch_a) begin
        chk("d0_latch_dark", int'(oe_n_a), 1);
        if (a_seen) begin
          chk("d0_period", a_cnt, 133);
          chk("d0_oe_low", a_low, 130);
        end
        a_seen = 1'b1; a_cnt = 0; a_low = 0;
      end
      if (latch_b) begin
        chk("d3_latch_dark", int'(oe_n_b), 1);
        if (b_seen) begin
          chk("d3_period", b_cnt, 136);
          chk("d3_oe_low", b_low, 133);
        end
        b_seen = 1'b1; b_cnt = 0; b_low = 0;
      end
    end
  end

  task automatic do_reset(input int mode, input logic [23:0] col);
    @(posedge clk);
    #1 resetn = 1'b0;
    fill(mode, col);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 60000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != target) chk("wait_cyc", cyc, target);
  endtask

  typedef struct {
    logic [23:0] col;
    int          sub;
    logic [2:0]  e0;
    logic [2:0]  e1;
  } vec_t;

  vec_t vecs [7];
  int   rises, good, g6;

  initial begin
    vecs[0] = '{24'hFFFFFF, 0, 3'd7, 3'd7};
    vecs[1] = '{24'h000010, 0, 3'd1, 3'd1};
    vecs[2] = '{24'h0F1700, 0, 3'd6, 3'd6};
    vecs[3] = '{24'h000000, 0, 3'd0, 3'd0};
    vecs[4] = '{24'h000010, 1, 3'd0, 3'd0};
    vecs[5] = '{24'h0F1700, 1, 3'd2, 3'd2};
    vecs[6] = '{24'hFFFFFF, 1, 3'd7, 3'd7};

    fill(1, 24'h0);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("t1_oe_n", int'(oe_n), 1);
    chk("t1_sclk", int'(sclk), 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Request order of the first row, random picture.
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      chk("t1_x", int'(x), k / 2);
      chk("t1_y", int'(y), (k % 2) * 32);
    end
    wait_cyc(66 * P);

    // Reset mid-row at request 70: outputs drop immediately, scan restarts from zero.
    g6 = 0;
    while (cyc % P != 70 && g6 < 400) begin
      @(negedge clk);
      g6++;
    end
    chk("t6_at_k70", cyc % P, 70);
    #1 resetn = 1'b0;
    #1;
    chk("t6_oe_n", int'(oe_n), 1);
    chk("t6_sclk", int'(sclk), 0);
    chk("t6_latch", int'(latch), 0);
    chk("t6_xy", int'({x, y}), 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("t6_x0", int'(x), 0);
    chk("t6_y0", int'(y), 0);
    chk("t6_sub0", int'(subframe), 0);
    @(negedge clk);
    chk("t6_y32", int'(y), 32);
    wait_cyc(4 * P);

    // Colour from row number: halves must never swap.
    do_reset(2, 24'h0);
    wait_cyc(36 * P);

    // Constant-colour vectors checked on every sclk rise of one row.
    for (int i = 0; i < 7; i++) begin
      do_reset(0, vecs[i].col);
      wait_cyc((vecs[i].sub == 0 ? 1 : 33) * P);
      chk("vec_sub", int'(subframe), vecs[i].sub);
      rises = 0;
      good  = 0;
      for (int c = 0; c < P; c++) begin
        if (sclk) begin
          rises++;
          if (rgb0 == vecs[i].e0 && rgb1 == vecs[i].e1) good++;
        end
        @(negedge clk);
      end
      chk("vec_rises", rises, 64);
      chk("vec_data", good, 64);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
